// File: rtl/idelay_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : idelay_sweep_ctrl
// Description : IDELAY calibration sequencer. Sweeps delay taps through the
//               DRP wrapper handshake, counts data/reference mismatches per
//               tap, finds the longest contiguous run of good taps, loads its
//               centre and reads the hardware count back.
//               Optional macro SWEEP_LOG_EN adds a per-tap log output.
// Revision    : 1.0 - initial release
// ============================================================================
module idelay_sweep_ctrl #(
    parameter int DWELL_W     = 16,
    parameter int ERR_W       = 12,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [8:0]         cfg_start_tap,
    input  logic [8:0]         cfg_end_tap,
    input  logic [8:0]         cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [ERR_W-1:0]   cfg_err_thresh,
    input  logic               sample_in,
    input  logic               ref_in,
    output logic               dly_change,
    output logic               dly_read,
    output logic [8:0]         dly_delay_in,
    input  logic               dly_done,
    input  logic [8:0]         dly_delay_out,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [8:0]         result_tap,
    output logic [9:0]         result_len,
    output logic [8:0]         readback_cnt
`ifdef SWEEP_LOG_EN
    ,
    output logic               log_valid,
    output logic [8:0]         log_tap,
    output logic [ERR_W-1:0]   log_err
`endif
);

    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_SET_TAP    = 4'd1,
        S_WAIT_SET   = 4'd2,
        S_SETTLE     = 4'd3,
        S_DWELL      = 4'd4,
        S_EVAL       = 4'd5,
        S_CENTER     = 4'd6,
        S_APPLY      = 4'd7,
        S_WAIT_APPLY = 4'd8,
        S_READBACK   = 4'd9,
        S_WAIT_READ  = 4'd10,
        S_FINISH     = 4'd11
    } state_t;

    state_t             state;
    logic [8:0]         end_q, step_q, cur_tap;
    logic [DWELL_W-1:0] dwell_q, dwell_cnt;
    logic [ERR_W-1:0]   thresh_q, err_count;
    logic [TMR_W-1:0]   timer;
    logic               run_open;
    logic [8:0]         run_start, run_end, best_start, best_end;
    logic [9:0]         run_len, best_len;

    logic               good, sweep_end, close_now, take_best;
    logic [9:0]         next_tap, upd_len, cand_len;
    logic [8:0]         upd_start, cand_start, cand_end, center_tap;

    // Tap evaluation: run-tracker update, candidate for best run, next tap.
    always_comb begin
        good       = (err_count <= thresh_q);
        next_tap   = {1'b0, cur_tap} + {1'b0, step_q};
        sweep_end  = next_tap[9] || (next_tap > {1'b0, end_q});
        upd_start  = run_open ? run_start : cur_tap;
        upd_len    = run_open ? (run_len + 10'd1) : 10'd1;
        // A bad tap closes the old run; a good tap at sweep end closes the
        // run including itself.
        cand_start = good ? upd_start : run_start;
        cand_end   = good ? cur_tap   : run_end;
        cand_len   = good ? upd_len   : run_len;
        close_now  = good ? sweep_end : run_open;
        take_best  = close_now && (cand_len > best_len);
        center_tap = 9'(({1'b0, best_start} + {1'b0, best_end}) >> 1);
    end

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            end_q        <= '0;
            step_q       <= '0;
            cur_tap      <= '0;
            dwell_q      <= '0;
            dwell_cnt    <= '0;
            thresh_q     <= '0;
            err_count    <= '0;
            timer        <= '0;
            run_open     <= 1'b0;
            run_start    <= '0;
            run_end      <= '0;
            run_len      <= '0;
            best_start   <= '0;
            best_end     <= '0;
            best_len     <= '0;
            dly_change   <= 1'b0;
            dly_read     <= 1'b0;
            dly_delay_in <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            result_tap   <= '0;
            result_len   <= '0;
            readback_cnt <= '0;
`ifdef SWEEP_LOG_EN
            log_valid    <= 1'b0;
            log_tap      <= '0;
            log_err      <= '0;
`endif
        end else begin
            dly_change <= 1'b0;
            dly_read   <= 1'b0;
            done       <= 1'b0;
`ifdef SWEEP_LOG_EN
            log_valid  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        end_q        <= cfg_end_tap;
                        step_q       <= (cfg_step == '0) ? 9'd1 : cfg_step;
                        dwell_q      <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                        thresh_q     <= cfg_err_thresh;
                        cur_tap      <= cfg_start_tap;
                        fail         <= 1'b0;
                        result_tap   <= '0;
                        result_len   <= '0;
                        readback_cnt <= '0;
                        busy         <= 1'b1;
                        run_open     <= 1'b0;
                        run_len      <= '0;
                        best_start   <= '0;
                        best_end     <= '0;
                        best_len     <= '0;
                        if (cfg_end_tap < cfg_start_tap) begin
                            fail  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_SET_TAP;
                        end
                    end
                end
                S_SET_TAP: begin
                    dly_delay_in <= cur_tap;
                    dly_change   <= 1'b1;
                    timer        <= '0;
                    err_count    <= '0;
                    state        <= S_WAIT_SET;
                end
                S_WAIT_SET: begin
                    if (dly_done) begin
                        timer <= '0;
                        state <= S_SETTLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        fail  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        dwell_cnt <= '0;
                        state     <= S_DWELL;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_DWELL: begin
                    if ((sample_in != ref_in) && (err_count != '1))
                        err_count <= err_count + ERR_W'(1);
                    if (dwell_cnt == dwell_q - DWELL_W'(1))
                        state <= S_EVAL;
                    else
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
                S_EVAL: begin
`ifdef SWEEP_LOG_EN
                    log_valid <= 1'b1;
                    log_tap   <= cur_tap;
                    log_err   <= err_count;
`endif
                    if (take_best) begin
                        best_start <= cand_start;
                        best_end   <= cand_end;
                        best_len   <= cand_len;
                    end
                    run_open <= good && !sweep_end;
                    if (good) begin
                        run_start <= upd_start;
                        run_end   <= cur_tap;
                        run_len   <= upd_len;
                    end else begin
                        run_len <= '0;
                    end
                    if (sweep_end) begin
                        state <= S_CENTER;
                    end else begin
                        cur_tap <= next_tap[8:0];
                        state   <= S_SET_TAP;
                    end
                end
                S_CENTER: begin
                    if (best_len == '0) begin
                        fail  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        result_tap <= center_tap;
                        result_len <= best_len;
                        state      <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    dly_delay_in <= result_tap;
                    dly_change   <= 1'b1;
                    timer        <= '0;
                    state        <= S_WAIT_APPLY;
                end
                S_WAIT_APPLY: begin
                    if (dly_done) begin
                        state <= S_READBACK;
                    end else if (timer == TIMEOUT_LAST) begin
                        fail  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_READBACK: begin
                    dly_read <= 1'b1;
                    timer    <= '0;
                    state    <= S_WAIT_READ;
                end
                S_WAIT_READ: begin
                    if (dly_done) begin
                        readback_cnt <= dly_delay_out;
                        state        <= S_FINISH;
                    end else if (timer == TIMEOUT_LAST) begin
                        fail  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idelay_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_idelay_sweep_ctrl
// Description : Directed table-driven bench for idelay_sweep_ctrl with a
//               behavioural IDELAY DRP wrapper and a per-tap data-eye model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idelay_sweep_ctrl;

    localparam int DWELL_W     = 16;
    localparam int ERR_W       = 12;
    localparam int SETTLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 255;
    localparam int LAT         = 3;

    logic               clk, rst_n, start;
    logic [8:0]         cfg_start_tap, cfg_end_tap, cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [ERR_W-1:0]   cfg_err_thresh;
    logic               sample_in, ref_in;
    logic               dly_change, dly_read, dly_done;
    logic [8:0]         dly_delay_in, dly_delay_out;
    logic               busy, done, fail;
    logic [8:0]         result_tap, readback_cnt;
    logic [9:0]         result_len;
`ifdef SWEEP_LOG_EN
    logic               log_valid;
    logic [8:0]         log_tap;
    logic [ERR_W-1:0]   log_err;
`endif

    idelay_sweep_ctrl #(
        .DWELL_W(DWELL_W), .ERR_W(ERR_W),
        .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_start_tap(cfg_start_tap), .cfg_end_tap(cfg_end_tap),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .cfg_err_thresh(cfg_err_thresh),
        .sample_in(sample_in), .ref_in(ref_in),
        .dly_change(dly_change), .dly_read(dly_read),
        .dly_delay_in(dly_delay_in), .dly_done(dly_done),
        .dly_delay_out(dly_delay_out),
        .busy(busy), .done(done), .fail(fail),
        .result_tap(result_tap), .result_len(result_len),
        .readback_cnt(readback_cnt)
`ifdef SWEEP_LOG_EN
        , .log_valid(log_valid), .log_tap(log_tap), .log_err(log_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapper model: responds LAT cycles after a change/read pulse.
    logic [8:0] model_tap, pend_tap;
    logic [3:0] pend_cnt;
    logic       hold_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_done  <= 1'b0;
            pend_cnt  <= '0;
            pend_tap  <= '0;
            model_tap <= '0;
        end else begin
            dly_done <= 1'b0;
            if ((dly_change || dly_read) && !hold_done) begin
                pend_cnt <= 4'(LAT);
                pend_tap <= dly_change ? dly_delay_in : model_tap;
            end else if (pend_cnt != 0) begin
                pend_cnt <= pend_cnt - 4'd1;
                if (pend_cnt == 4'd1) begin
                    dly_done  <= 1'b1;
                    model_tap <= pend_tap;
                end
            end
        end
    end
    // Hardware count readback is offset from the tap so it cannot be confused with it.
    assign dly_delay_out = model_tap + 9'd3;

    // Data eye: taps inside a good window match the reference.
    int g0lo, g0hi, g1lo, g1hi;
    always @(negedge clk) begin
        ref_in    = 1'($urandom_range(0, 1));
        sample_in = ref_in ^ !((int'(model_tap) >= g0lo && int'(model_tap) <= g0hi) ||
                               (int'(model_tap) >= g1lo && int'(model_tap) <= g1hi));
    end

    // Handshake monitor.
    int         n_change = 0, n_read = 0, n_overlap = 0;
    logic [8:0] chg_log [0:1023];
    always @(posedge clk) begin
        if (dly_change) begin
            chg_log[n_change % 1024] = dly_delay_in;
            n_change++;
        end
        if (dly_read) n_read++;
        if (dly_change && dly_read) n_overlap++;
    end

    int n_checks = 0, n_errors = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0]  st, en, step;
        logic [15:0] dwell;
        logic [11:0] thr;
        int          g0lo, g0hi, g1lo, g1hi;
        bit          hold, efail;
        logic [8:0]  etap;
        logic [9:0]  elen;
        logic [8:0]  erb;
        int          echg, cmin, cmax;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];
    int   bases [NV];

    task automatic run_vec(input vec_t v, input int idx, output int base);
        int cyc;
        bit got;
        int base_rd;
        g0lo = v.g0lo; g0hi = v.g0hi; g1lo = v.g1lo; g1hi = v.g1hi;
        hold_done      = v.hold;
        cfg_start_tap  = v.st;
        cfg_end_tap    = v.en;
        cfg_step       = v.step;
        cfg_dwell      = v.dwell;
        cfg_err_thresh = v.thr;
        base    = n_change;
        base_rd = n_read;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk($sformatf("v%0d busy_hi", idx), 64'(busy), 64'd1);
        got = done;
        while (!got && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            got = done;
        end
        chk($sformatf("v%0d done_seen", idx), 64'(got), 64'd1);
        if (got) begin
            chk($sformatf("v%0d cycles_in_range", idx),
                64'(cyc >= v.cmin && cyc <= v.cmax), 64'd1);
            chk($sformatf("v%0d fail", idx), 64'(fail), 64'(v.efail));
            chk($sformatf("v%0d result_tap", idx), 64'(result_tap), 64'(v.etap));
            chk($sformatf("v%0d result_len", idx), 64'(result_len), 64'(v.elen));
            chk($sformatf("v%0d readback_cnt", idx), 64'(readback_cnt), 64'(v.erb));
            chk($sformatf("v%0d change_pulses", idx), 64'(n_change - base), 64'(v.echg));
            chk($sformatf("v%0d read_pulses", idx), 64'(n_read - base_rd), 64'(v.efail ? 0 : 1));
            if (v.echg > 0)
                chk($sformatf("v%0d first_tap", idx), 64'(chg_log[base % 1024]), 64'(v.st));
            if (!v.efail && v.echg > 0)
                chk($sformatf("v%0d applied_tap", idx),
                    64'(chg_log[(n_change - 1) % 1024]), 64'(v.etap));
            @(negedge clk);
            chk($sformatf("v%0d busy_lo", idx), 64'(busy), 64'd0);
            chk($sformatf("v%0d done_pulse_1cyc", idx), 64'(done), 64'd0);
        end
        hold_done = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wcyc;
        // st, en, step, dwell, thr, g0lo,g0hi, g1lo,g1hi, hold, efail, etap, elen, erb, echg, cmin, cmax
        vecs[0] = '{9'd0,   9'd40,  9'd1, 16'd64, 12'd0, 10, 30,  1, 0, 1'b0, 1'b0, 9'd20,  10'd21, 9'd23,  42, 1, 20000};
        vecs[1] = '{9'd0,   9'd30,  9'd1, 16'd8,  12'd0,  5,  9, 20, 24, 1'b0, 1'b0, 9'd7,   10'd5,  9'd10,  32, 1, 20000};
        vecs[2] = '{9'd500, 9'd511, 9'd8, 16'd16, 12'd0,  0, 511, 1, 0, 1'b0, 1'b0, 9'd504, 10'd2,  9'd507, 3,  1, 20000};
        vecs[3] = '{9'd100, 9'd103, 9'd0, 16'd0,  12'd0,  0, 511, 1, 0, 1'b0, 1'b0, 9'd101, 10'd4,  9'd104, 5,  1, 20000};
        vecs[4] = '{9'd0,   9'd3,   9'd1, 16'd8,  12'd8,  1,  0,  1, 0, 1'b0, 1'b0, 9'd1,   10'd4,  9'd4,   5,  1, 20000};
        vecs[5] = '{9'd0,   9'd3,   9'd1, 16'd8,  12'd7,  1,  0,  1, 0, 1'b0, 1'b1, 9'd0,   10'd0,  9'd0,   4,  1, 20000};
        vecs[6] = '{9'd10,  9'd5,   9'd1, 16'd8,  12'd0,  0, 511, 1, 0, 1'b0, 1'b1, 9'd0,   10'd0,  9'd0,   0,  1, 3};
        vecs[7] = '{9'd0,   9'd3,   9'd1, 16'd8,  12'd0,  0, 511, 1, 0, 1'b1, 1'b1, 9'd0,   10'd0,  9'd0,   1,  TIMEOUT_CYC, TIMEOUT_CYC + 5};

        rst_n = 1'b0; start = 1'b0; hold_done = 1'b0;
        cfg_start_tap = '0; cfg_end_tap = '0; cfg_step = '0;
        cfg_dwell = '0; cfg_err_thresh = '0;
        g0lo = 0; g0hi = 511; g1lo = 1; g1hi = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero",
            64'({dly_change, dly_read, dly_delay_in, busy, done, fail,
                 result_tap, result_len, readback_cnt}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i, base);
            bases[i] = base;
            repeat (2) @(negedge clk);
        end

        // High-tap sweep must step 500 -> 508 and stop, never wrapping low.
        chk("v2 second_tap", 64'(chg_log[(bases[2] + 1) % 1024]), 64'd508);

        // Reset asserted mid-dwell abandons the sweep.
        g0lo = 0; g0hi = 511; g1lo = 1; g1hi = 0;
        cfg_start_tap = 9'd500; cfg_end_tap = 9'd511; cfg_step = 9'd8;
        cfg_dwell = 16'd64; cfg_err_thresh = '0;
        base = n_change;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wcyc = 0;
        while (n_change == base && wcyc < 50) begin
            @(negedge clk);
            wcyc++;
        end
        chk("rst_seq change_seen", 64'(n_change > base), 64'd1);
        repeat (30) @(negedge clk);
        chk("rst_seq busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_seq outputs_zero",
            64'({dly_change, dly_read, dly_delay_in, busy, done, fail,
                 result_tap, result_len, readback_cnt}), 64'd0);
        repeat (3) @(negedge clk);
        chk("rst_seq no_done_in_reset", 64'({done, busy}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vecs[1], 8, base);

        chk("no_change_read_overlap", 64'(n_overlap), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
